// File: rtl/decim_avg_iq_mc.sv
// Multi-channel I/Q block-average decimator: sums 2^k beats per channel/rail, emits a rounded mean.
// Optional macro DECIM_AVG_EOB_FLUSH_EN: an accepted in_tlast dumps the partial block immediately.
module decim_avg_iq_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 2,
    parameter int MAX_DEC_LOG2 = 7
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]    dec_log2,
    input  logic                                 in_tvalid,
    output logic                                 in_tready,
    input  logic                                 in_tlast,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         in_itdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         in_qtdata,
    output logic                                 out_tvalid,
    input  logic                                 out_tready,
    output logic                                 out_tlast,
    output logic [NUM_CH*DATA_WIDTH-1:0]         out_itdata,
    output logic [NUM_CH*DATA_WIDTH-1:0]         out_qtdata
);
    localparam int KW    = $clog2(MAX_DEC_LOG2 + 1);
    localparam int ACC_W = DATA_WIDTH + MAX_DEC_LOG2;
    localparam int CW    = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

    // Round half toward +inf, then arithmetic shift by k.
    function automatic logic signed [DATA_WIDTH-1:0] round_shift(
        input logic signed [ACC_W:0] sum,
        input logic [KW-1:0]         k
    );
        logic signed [ACC_W:0] bias;
        logic signed [ACC_W:0] shifted;
        bias = '0;
        if (k != '0)
            bias = (ACC_W+1)'(1) << (k - KW'(1));
        shifted = (sum + bias) >>> k;
        return shifted[DATA_WIDTH-1:0];
    endfunction

    logic [KW-1:0]                  k_act;
    logic [KW-1:0]                  k_new;
    logic [KW-1:0]                  k_use;
    logic [CW-1:0]                  count;
    logic [CW:0]                    last_cnt;
    logic                           tlast_flag;
    logic                           beat;
    logic                           flush;
    logic                           dump;
    logic signed [ACC_W-1:0]        acc_i [NUM_CH];
    logic signed [ACC_W-1:0]        acc_q [NUM_CH];
    logic signed [DATA_WIDTH-1:0]   samp_i [NUM_CH];
    logic signed [DATA_WIDTH-1:0]   samp_q [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0]   data_i_p1;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_q_p1;
    logic                           vld_p1;
    logic                           last_p1;

    assign in_tready  = !(vld_p1 && !out_tready);
    assign out_tvalid = vld_p1;
    assign out_tlast  = last_p1;
    assign out_itdata = data_i_p1;
    assign out_qtdata = data_q_p1;

    // Stage p0: accept beat, pick exponent, decide accumulate vs dump.
    always_comb begin
        k_new = dec_log2;
        if (int'(dec_log2) > MAX_DEC_LOG2)
            k_new = KW'(MAX_DEC_LOG2);
        k_use    = (count == '0) ? k_new : k_act;
        last_cnt = (CW+1)'((1 << k_use) - 1);
        beat     = in_tvalid && in_tready;
`ifdef DECIM_AVG_EOB_FLUSH_EN
        flush    = in_tlast;
`else
        flush    = 1'b0;
`endif
        dump     = beat && (({1'b0, count} == last_cnt) || flush);
        for (int c = 0; c < NUM_CH; c++) begin
            samp_i[c] = $signed(in_itdata[c*DATA_WIDTH +: DATA_WIDTH]);
            samp_q[c] = $signed(in_qtdata[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Stage p1: output register, loaded on dump and held under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            data_i_p1  <= '0;
            data_q_p1  <= '0;
            count      <= '0;
            k_act      <= '0;
            tlast_flag <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
        end else begin
            if (vld_p1 && out_tready)
                vld_p1 <= 1'b0;
            if (clear) begin
                count      <= '0;
                tlast_flag <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    acc_i[c] <= '0;
                    acc_q[c] <= '0;
                end
            end else if (beat) begin
                if (count == '0)
                    k_act <= k_new;
                if (dump) begin
                    vld_p1     <= 1'b1;
                    last_p1    <= tlast_flag | in_tlast;
                    count      <= '0;
                    tlast_flag <= 1'b0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        data_i_p1[c*DATA_WIDTH +: DATA_WIDTH] <= round_shift(
                            (ACC_W+1)'(acc_i[c]) + (ACC_W+1)'(samp_i[c]), k_use);
                        data_q_p1[c*DATA_WIDTH +: DATA_WIDTH] <= round_shift(
                            (ACC_W+1)'(acc_q[c]) + (ACC_W+1)'(samp_q[c]), k_use);
                        acc_i[c] <= '0;
                        acc_q[c] <= '0;
                    end
                end else begin
                    count      <= count + 1'b1;
                    tlast_flag <= tlast_flag | in_tlast;
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc_i[c] <= acc_i[c] + ACC_W'(samp_i[c]);
                        acc_q[c] <= acc_q[c] + ACC_W'(samp_q[c]);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_decim_avg_iq_mc.sv
// Directed bench for decim_avg_iq_mc: block-level reference model plus literal spot checks.
module tb_decim_avg_iq_mc;
    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int MAXK = 7;
    localparam int KW   = 3;
`ifdef DECIM_AVG_EOB_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, clear;
    logic [KW-1:0]      dec_log2;
    logic               in_tvalid, in_tready, in_tlast;
    logic [NCH*DW-1:0]  in_itdata, in_qtdata;
    logic               out_tvalid, out_tready, out_tlast;
    logic [NCH*DW-1:0]  out_itdata, out_qtdata;

    always #5 clk = ~clk;

    decim_avg_iq_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_DEC_LOG2(MAXK)) dut (
        .clk(clk), .reset(reset), .clear(clear), .dec_log2(dec_log2),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .in_itdata(in_itdata), .in_qtdata(in_qtdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_itdata(out_itdata), .out_qtdata(out_qtdata)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sl(input logic [NCH*DW-1:0] v, input int c);
        return int'($signed(v[c*DW +: DW]));
    endfunction

    // Reference model: collects a block of samples, averages when the block is complete.
    typedef struct { int i0; int q0; int i1; int q1; } beat_t;
    beat_t blk[$];
    beat_t m_b;
    int    m_k = 0;
    bit    m_flag = 0, m_vld = 0, m_last = 0, m_acc;
    int    m_i0 = 0, m_q0 = 0, m_i1 = 0, m_q1 = 0;

    function automatic int avg(input int sel);
        longint s = 0;
        longint r;
        foreach (blk[j]) begin
            case (sel)
                0: s += blk[j].i0;
                1: s += blk[j].q0;
                2: s += blk[j].i1;
                default: s += blk[j].q1;
            endcase
        end
        r = (m_k > 0) ? (longint'(1) << (m_k - 1)) : 0;
        return int'((s + r) >>> m_k);
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            blk.delete();
            m_k = 0; m_flag = 0; m_vld = 0; m_last = 0;
            m_i0 = 0; m_q0 = 0; m_i1 = 0; m_q1 = 0;
        end else begin
            m_acc = in_tvalid && !(m_vld && !out_tready);
            if (m_vld && out_tready) m_vld = 0;
            if (clear) begin
                blk.delete();
                m_flag = 0;
            end else if (m_acc) begin
                if (blk.size() == 0) m_k = (int'(dec_log2) > MAXK) ? MAXK : int'(dec_log2);
                m_b.i0 = sl(in_itdata, 0); m_b.i1 = sl(in_itdata, 1);
                m_b.q0 = sl(in_qtdata, 0); m_b.q1 = sl(in_qtdata, 1);
                blk.push_back(m_b);
                m_flag = m_flag | in_tlast;
                if (blk.size() == (1 << m_k) || (FLUSH && in_tlast)) begin
                    m_i0 = avg(0); m_q0 = avg(1); m_i1 = avg(2); m_q1 = avg(3);
                    m_vld = 1; m_last = m_flag;
                    m_flag = 0;
                    blk.delete();
                end
            end
        end
    end

    logic [NCH*DW-1:0] exp_i, exp_q;
    initial forever begin
        @(negedge clk);
        if (run_cmp && !reset) begin
            exp_i = {m_i1[DW-1:0], m_i0[DW-1:0]};
            exp_q = {m_q1[DW-1:0], m_q0[DW-1:0]};
            chk("in_tready", int'(in_tready), int'(!(m_vld && !out_tready)));
            chk("out_tvalid", int'(out_tvalid), int'(m_vld));
            chk("out_tlast", int'(out_tlast), int'(m_last));
            chk("out_itdata", int'(out_itdata), int'(exp_i));
            chk("out_qtdata", int'(out_qtdata), int'(exp_q));
        end
    end

    int seen_i0[$], seen_i1[$], seen_q1[$], seen_last[$];
    initial forever begin
        @(posedge clk);
        if (!reset && out_tvalid && out_tready) begin
            seen_i0.push_back(sl(out_itdata, 0));
            seen_i1.push_back(sl(out_itdata, 1));
            seen_q1.push_back(sl(out_qtdata, 1));
            seen_last.push_back(int'(out_tlast));
        end
    end

    task automatic clr_seen();
        seen_i0.delete(); seen_i1.delete(); seen_q1.delete(); seen_last.delete();
    endtask

    task automatic send(input int i0, input int q0, input int i1, input int q1, input bit last);
        bit ok = 0;
        in_itdata = {i1[DW-1:0], i0[DW-1:0]};
        in_qtdata = {q1[DW-1:0], q0[DW-1:0]};
        in_tlast  = last;
        in_tvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_tready) begin ok = 1; break; end
        end
        chk("in_accept", int'(ok), 1);
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int t = 0; t < 400; t++) begin
            if (seen_i0.size() >= n) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("beat_count", seen_i0.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; dec_log2 = '0;
        in_tvalid = 1'b0; in_tlast = 1'b0; in_itdata = '0; in_qtdata = '0;
        out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_cmp = 1'b1;
        reset   = 1'b0;
        @(negedge clk);
        chk("rst_tready", int'(in_tready), 1);
        chk("rst_tvalid", int'(out_tvalid), 0);
        chk("rst_out_i", int'(out_itdata), 0);
        chk("rst_out_q", int'(out_qtdata), 0);
        @(posedge clk); #1;

        // k=2 average, one clock latency after the fourth beat
        dec_log2 = 3'd2;
        clr_seen();
        for (int n = 1; n <= 4; n++) send(n, 0, 10, -7, 0);
        @(negedge clk);
        chk("k2_vld", int'(out_tvalid), 1);
        chk("k2_i0", sl(out_itdata, 0), 3);
        chk("k2_i1", sl(out_itdata, 1), 10);
        chk("k2_q1", sl(out_qtdata, 1), -7);
        @(posedge clk); #1;
        wait_beats(1);

        // k=1 negative rounding on ch1 Q; ch0 independent
        dec_log2 = 3'd1;
        clr_seen();
        send(5, 0, 0, -3, 0);
        send(5, 0, 0, -2, 0);
        wait_beats(1);
        if (seen_i0.size() >= 1) begin
            chk("k1_q1", seen_q1[0], -2);
            chk("k1_i0", seen_i0[0], 5);
        end

        // k=7 full-scale extremes
        dec_log2 = 3'd7;
        clr_seen();
        repeat (128) send(32767, 32767, 32767, 32767, 0);
        repeat (128) send(-32768, -32768, -32768, -32768, 0);
        wait_beats(2);
        if (seen_i0.size() >= 2) begin
            chk("k7_pos_i0", seen_i0[0], 32767);
            chk("k7_pos_q1", seen_q1[0], 32767);
            chk("k7_neg_i0", seen_i0[1], -32768);
            chk("k7_neg_q1", seen_q1[1], -32768);
        end

        // k=0 pass-through with downstream stall
        dec_log2 = 3'd0;
        clr_seen();
        out_tready = 1'b0;
        send(11, 1, 0, 0, 0);
        fork
            begin
                send(22, 2, 0, 0, 0);
                send(33, 3, 0, 0, 0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tready", int'(in_tready), 0);
                    chk("stall_i0", sl(out_itdata, 0), 11);
                end
                @(posedge clk); #1;
                out_tready = 1'b1;
            end
        join
        wait_beats(3);
        if (seen_i0.size() >= 3) begin
            chk("k0_beat0", seen_i0[0], 11);
            chk("k0_beat1", seen_i0[1], 22);
            chk("k0_beat2", seen_i0[2], 33);
        end

        // tlast on beat 2 of a k=2 block, then clear flushes any remainder
        dec_log2 = 3'd2;
        clr_seen();
        send(4, 0, 0, 0, 0);
        send(8, 0, 0, 0, 1);
        send(12, 0, 0, 0, 0);
        send(16, 0, 0, 0, 0);
        send(20, 0, 0, 0, 0);
        send(24, 0, 0, 0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
`ifdef DECIM_AVG_EOB_FLUSH_EN
        wait_beats(2);
        if (seen_i0.size() >= 2) begin
            chk("eob_i0", seen_i0[0], 3);
            chk("eob_last", seen_last[0], 1);
            chk("eob_next_i0", seen_i0[1], 18);
            chk("eob_next_last", seen_last[1], 0);
        end
`else
        wait_beats(1);
        if (seen_i0.size() >= 1) begin
            chk("tlast_i0", seen_i0[0], 10);
            chk("tlast_last", seen_last[0], 1);
        end
`endif
        dec_log2 = 3'd1;
        clr_seen();
        send(6, 0, 0, 0, 0);
        send(7, 0, 0, 0, 0);
        wait_beats(1);
        if (seen_i0.size() >= 1) begin
            chk("after_clear_i0", seen_i0[0], 7);
            chk("after_clear_last", seen_last[0], 0);
        end

        // reset mid-block drops the partial sum
        dec_log2 = 3'd2;
        clr_seen();
        repeat (3) send(100, 0, 100, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send(1, 0, -1, 0, 0);
        send(1, 0, -1, 0, 0);
        send(1, 0, -1, 0, 0);
        send(2, 0, -1, 0, 0);
        wait_beats(1);
        if (seen_i0.size() >= 1) begin
            chk("rst_mid_i0", seen_i0[0], 1);
            chk("rst_mid_i1", seen_i1[0], -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/decim_avg_iq_mc.md
DECIM_AVG_IQ_MC -- requirements
Module: decim_avg_iq_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of each I or Q sample.
REQ-002 SHALL have parameter NUM_CH, default 2, number of parallel I/Q channels sharing one handshake.
REQ-003 SHALL have parameter MAX_DEC_LOG2, default 7, largest decimation exponent (max rate 2^MAX_DEC_LOG2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  in  1  synchronous flush of accumulators and counter; output register untouched.
REQ-007 SHALL have port dec_log2  in  $clog2(MAX_DEC_LOG2+1)  decimation exponent k, rate 2^k.
REQ-008 SHALL have port in_tvalid  in  1  input beat valid.
REQ-009 SHALL have port in_tready  out  1  input beat accepted when high with in_tvalid.
REQ-010 SHALL have port in_tlast  in  1  end-of-burst marker.
REQ-011 SHALL have port in_itdata / in_qtdata  in  NUM_CH*DATA_WIDTH each  packed I / Q, channel 0 in LSBs.
REQ-012 SHALL have port out_tvalid  out  1  decimated beat valid.
REQ-013 SHALL have port out_tready  in  1  downstream ready.
REQ-014 SHALL have port out_tlast  out  1  end-of-burst on decimated beat.
REQ-015 SHALL have port out_itdata / out_qtdata  out  NUM_CH*DATA_WIDTH each  packed decimated I / Q.

Function
REQ-016 SHALL assign in_tready = NOT(out_tvalid AND NOT out_tready); beat accepted = in_tvalid AND in_tready.
REQ-017 SHALL hold per-channel, per-rail signed accumulators of width DATA_WIDTH+MAX_DEC_LOG2; no overflow possible.
REQ-018 SHALL latch active exponent k_act from dec_log2 on the accepted beat with count==0; values >MAX_DEC_LOG2 clamp to MAX_DEC_LOG2; dec_log2 changes mid-block are ignored.
REQ-019 SHALL, on accepted beat with count<2^k_act-1, add the sample to the accumulator and increment count.
REQ-020 SHALL, on accepted beat with count==2^k_act-1 (dump), load output register with (acc+sample+R)>>>k_act (arithmetic), R=2^(k_act-1) for k_act>0, else 0 (round half toward +inf); reset accumulators and count to 0 in the same cycle.
REQ-021 SHALL assert out_tvalid the cycle after the dump edge (latency 1 clk from last accepted input); k=0 is pass-through with 1-clk latency.
REQ-022 SHALL hold out_* stable while out_tvalid=1 and out_tready=0; clear out_tvalid on out_tvalid AND out_tready unless a new dump loads in the same cycle.
REQ-023 SHALL allow dump and output handshake in the same cycle (back-to-back beats at full rate for k=0).
REQ-024 SHALL latch a sticky tlast flag on any accepted in_tlast; out_tlast = flag value at dump; flag cleared on dump.
REQ-025 SHALL, on clear, zero accumulators, count and tlast flag; an in-flight out beat still completes.
REQ-026 SHALL process all channels in lockstep; each channel's result depends only on its own samples.

Reset
REQ-027 SHALL, on reset, drive out_tvalid=0, out_tlast=0, out_itdata=0, out_qtdata=0, accumulators=0, count=0, k_act=0, tlast flag=0.
REQ-028 SHALL have in_tready=1 the cycle after reset deasserts.
REQ-029 SHALL let reset mid-block discard the partial sum with no output beat.

Configuration
REQ-030 SHALL honour macro DECIM_AVG_EOB_FLUSH_EN: when defined, an accepted in_tlast with count<2^k_act-1 forces an immediate dump (partial sum, same k_act shift and R), out_tlast=1, count reset.
REQ-031 SHALL, without DECIM_AVG_EOB_FLUSH_EN, handle in_tlast only per REQ-024 (no early dump).

Verification
REQ-032 SHALL verify: k=2, ch0 I inputs 1,2,3,4 -> one beat, out I=3 ((10+2)>>2), 1 clk after 4th beat.
REQ-033 SHALL verify: k=1, ch1 Q inputs -3,-2 -> out Q=-2 ((-5+1)>>>1); ch0 unaffected.
REQ-034 SHALL verify: k=7, all samples 32767 for 128 beats -> out 32767; all -32768 -> out -32768.
REQ-035 SHALL verify: k=0, out_tready held 0 for 5 clks after first beat -> in_tready=0, out data stable, no beats lost after release.
REQ-036 SHALL verify: k=2, in_tlast on beat 2 -> with macro: beat out after beat 2, out_tlast=1; without: out_tlast=1 on 4th-beat dump.
REQ-037 SHALL verify: reset after 3 of 4 beats (k=2) -> no output; next 4 beats produce correct average.
